// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with programmable thresholds, sticky error
// flags and an optional first-word-fall-through read port.
module sync_fifo_flex #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 5,
  parameter int AF_THRESH  = (1 << DEPTH_BITS) - 4,
  parameter int AE_THRESH  = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      data_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [DEPTH_BITS:0]   fifo_counter,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CNT_W = DEPTH_BITS + 1;

  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] C_AE   = CNT_W'(AE_THRESH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [WIDTH-1:0]      w_head;

  // Request/accept: a request has effect only in a cycle where it is
  // accepted; there is no stall, a rejected request is simply dropped and
  // recorded in the sticky error flags. A read at empty never bypasses a
  // concurrent write; a write at full is accepted only with a concurrent read.
  assign w_empty  = (r_count == C_ZERO);
  assign w_full   = (r_count == C_FULL);
  assign w_rd_acc = read && !w_empty;
  assign w_wr_acc = write && (!w_full || w_rd_acc);
  assign w_head   = r_mem[r_rd_ptr];

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Setting takes priority over clear_err so a coincident error is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write && !w_wr_acc) r_overflow <= 1'b1;
      else if (clear_err)     r_overflow <= 1'b0;

      if (read && w_empty)    r_underflow <= 1'b1;
      else if (clear_err)     r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = w_empty ? '0 : w_head;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_out;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_data_out <= '0;
        end else if (w_rd_acc) begin
          r_data_out <= w_head;
        end
      end

      assign data_out = r_data_out;
    end
  endgenerate

  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign almost_empty = (r_count <= C_AE);
  assign almost_full  = (r_count >= C_AF);
  assign fifo_counter = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO that replaces the fixed 16-bit, 32-entry synchronous FIFO used throughout the datapath. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between any two same-clock producer/consumer stages that need elastic buffering.

## Interface
- WIDTH, 16: data word width in bits.
- DEPTH_BITS, 5: log2 of depth; DEPTH = 2**DEPTH_BITS entries.
- AF_THRESH, DEPTH-4: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 4: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- write  in  1  write request; data_in captured when accepted.
- read  in  1  read request.
- data_in  in  WIDTH  write data.
- clear_err  in  1  clears overflow/underflow on the next edge.
- data_out  out  WIDTH  read data (see Operation).
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- fifo_counter  out  DEPTH_BITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Storage: DEPTH x WIDTH array; wr_ptr and rd_ptr are DEPTH_BITS wide and wrap from DEPTH-1 to 0 naturally.
- Occupancy is an explicit DEPTH_BITS+1 counter (holds DEPTH without aliasing).
- Read accepted: rd_acc = read && !fifo_empty.
- Write accepted: wr_acc = write && (!fifo_full || rd_acc).
  - When full, a simultaneous read frees a slot and the write is accepted.
  - When empty, a simultaneous read is rejected (no bypass); the write is accepted.
- On wr_acc: mem[wr_ptr] <= data_in, wr_ptr++.
- On rd_acc: rd_ptr++.
- Counter: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Rejected write leaves wr_ptr, memory and counter unchanged. Rejected read leaves rd_ptr and data_out unchanged.
- Error flags:
  - overflow sets on write && !wr_acc; underflow sets on read && fifo_empty.
  - Both hold until clear_err or reset. If set and clear coincide, set wins.
- data_out, FWFT=0: registered; on rd_acc, data_out <= mem[rd_ptr]; otherwise holds.
- data_out, FWFT=1: equals mem[rd_ptr] whenever !fifo_empty, and 0 when empty; read acts as a pop/acknowledge.
- All status flags are decoded from the registered counter; no flag depends combinationally on write or read.

## Timing
- Reset values: pointers 0, counter 0, fifo_empty 1, fifo_full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, data_out 0. Memory contents are not reset.
- Reset overrides write/read in the same cycle. Asserting reset mid-stream discards all contents at that edge.
- Write-to-status latency: 1 cycle. fifo_empty deasserts on the edge that accepts the first write.
- Read latency, FWFT=0: data valid on data_out the cycle after the read request, and held until the next accepted read.
- Read latency, FWFT=1: head word visible 1 cycle after it is written into an empty FIFO. After an accepted read, the next word appears on the following cycle.
- Throughput: one write and one read per cycle, sustained, at any occupancy.

## Test plan
- Reset: hold reset 2 cycles with write=1 -> counter 0, fifo_empty 1, fifo_full 0, overflow 0, data_out 0.
- Fill/drain (WIDTH=16, DEPTH_BITS=5, FWFT=0): write 0x0000..0x001F -> fifo_full after the 32nd write, almost_full from count 28. Then read 32 times -> data_out 0x0000..0x001F in order, each one cycle after its read. fifo_empty after the last read; almost_empty at count 4.
- Overflow: when full, write 0xDEAD with read=0 -> wr_ptr stable, counter stays 32, overflow=1 and sticky. Drain all -> no 0xDEAD out. Pulse clear_err -> overflow=0.
- Underflow / simultaneous-at-empty: when empty, read=1, write=1, data 0x1234 -> underflow=1, counter=1. The next read returns 0x1234.
- Full simultaneous: when full, read=1, write=1, data 0xBEEF -> counter stays 32, no overflow. 0xBEEF emerges as the 32nd word after it; pointers wrap through 0.
- FWFT=1: write 0x00AA into an empty FIFO -> data_out=0x00AA the next cycle with no read. Read -> data_out 0 and fifo_empty=1 the next cycle.
